// File: rtl/change_dispenser_if.sv
// Request/status bundle between the credit logic (master) and the coin dispenser (slave).
// tube_empty is combinational from the dispenser's tube counters.
interface change_dispenser_if;
  logic       start;
  logic [7:0] change_amt;
  logic       abort;
  logic       refill;
  logic [3:0] eject;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] remaining;
  logic [3:0] tube_empty;

  modport master (
    output start, change_amt, abort, refill,
    input  eject, busy, done, short, remaining, tube_empty
  );

  modport slave (
    input  start, change_amt, abort, refill,
    output eject, busy, done, short, remaining, tube_empty
  );
endinterface

// File: rtl/change_dispenser.sv
// Coin-return sequencer: pays a nickel amount greedily from dollar/quarter/dime/nickel tubes,
// one solenoid pulse at a time, tracking tube stock and reporting any unpaid remainder.
module change_dispenser #(
  parameter int unsigned EJECT_CYCLES = 5_000_000,
  parameter int unsigned GAP_CYCLES   = 2_500_000,
  parameter int unsigned TUBE_INIT    = 20,
  parameter int unsigned TUBE_W       = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  change_dispenser_if.slave   bus
);

  typedef enum logic [2:0] {StIdle, StSelect, StEject, StGap, StFinish} state_e;

  localparam logic [TUBE_W-1:0] TubeFull  = TUBE_W'(TUBE_INIT);
  localparam logic [31:0]       EjectLast = 32'(EJECT_CYCLES - 1);
  localparam logic [31:0]       GapLast   = 32'(GAP_CYCLES - 1);

  state_e            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [3:0]        eject_q, eject_d;
  logic [7:0]        rem_q, rem_d;
  logic              short_q, short_d;
  logic [TUBE_W-1:0] tube_q [4];
  logic [TUBE_W-1:0] tube_d [4];
  logic [3:0]        empty;
  logic [3:0]        pick;
  logic [7:0]        coin_val;

  always_comb begin
    empty = '0;
    for (int i = 0; i < 4; i++) empty[i] = (tube_q[i] == '0);
  end

  // Largest stocked denomination that still fits; zero when nothing can be paid.
  always_comb begin
    pick = 4'b0000;
    if (rem_q >= 8'd20 && !empty[3])      pick = 4'b1000;
    else if (rem_q >= 8'd5 && !empty[2])  pick = 4'b0100;
    else if (rem_q >= 8'd2 && !empty[1])  pick = 4'b0010;
    else if (rem_q >= 8'd1 && !empty[0])  pick = 4'b0001;
  end

  always_comb begin
    unique case (eject_q)
      4'b1000: coin_val = 8'd20;
      4'b0100: coin_val = 8'd5;
      4'b0010: coin_val = 8'd2;
      4'b0001: coin_val = 8'd1;
      default: coin_val = 8'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    eject_d = eject_q;
    rem_d   = rem_q;
    short_d = short_q;
    tube_d  = tube_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          rem_d   = bus.change_amt;
          short_d = 1'b0;
          state_d = StSelect;
        end else if (bus.refill) begin
          for (int i = 0; i < 4; i++) tube_d[i] = TubeFull;
        end
      end
      StSelect: begin
        cnt_d = '0;
        if (bus.abort || pick == 4'b0000) begin
          state_d = StFinish;
        end else begin
          eject_d = pick;
          state_d = StEject;
        end
      end
      StEject: begin
        if (cnt_q == EjectLast) begin
          cnt_d   = '0;
          eject_d = 4'b0000;
          rem_d   = rem_q - coin_val;
          for (int i = 0; i < 4; i++) begin
            if (eject_q[i] && tube_q[i] != '0) tube_d[i] = tube_q[i] - TUBE_W'(1);
          end
          state_d = StGap;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StGap: begin
        if (bus.abort) begin
          state_d = StFinish;
        end else if (cnt_q == GapLast) begin
          cnt_d   = '0;
          state_d = StSelect;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StFinish: begin
        short_d = (rem_q != 8'd0);
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      eject_q <= 4'b0000;
      rem_q   <= 8'd0;
      short_q <= 1'b0;
      for (int i = 0; i < 4; i++) tube_q[i] <= TubeFull;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      eject_q <= eject_d;
      rem_q   <= rem_d;
      short_q <= short_d;
      tube_q  <= tube_d;
    end
  end

  assign bus.eject      = eject_q;
  assign bus.busy       = (state_q != StIdle);
  assign bus.done       = (state_q == StFinish);
  assign bus.short      = short_q;
  assign bus.remaining  = rem_q;
  assign bus.tube_empty = empty;

endmodule

// File: tb/tb_change_dispenser.sv
// Randomised self-checking bench: a greedy-payout model with the latency formula predicts
// every cycle of eject/done and the final short/remaining/tube state.
module tb_change_dispenser;
  localparam int E = 2;
  localparam int G = 1;
  localparam int TubeInit = 3;
  localparam int Val [4] = '{1, 2, 5, 20};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  int   mdl_tube [4];

  change_dispenser_if bus ();

  change_dispenser #(
    .EJECT_CYCLES(E),
    .GAP_CYCLES  (G),
    .TUBE_INIT   (TubeInit),
    .TUBE_W      (6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] mdl_empty();
    logic [3:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) e[i] = (mdl_tube[i] == 0);
    return e;
  endfunction

  task automatic mdl_fill();
    for (int i = 0; i < 4; i++) mdl_tube[i] = TubeInit;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mdl_fill();
  endtask

  // Issue one request and check every busy cycle plus the idle state that follows.
  task automatic run_req(input logic [7:0] amt, input bit noise, input string name);
    logic [3:0] exp_ej [$];
    bit         exp_dn [$];
    logic [3:0] oh;
    int         rem;
    rem = amt;
    for (int d = 3; d >= 0; d--) begin
      while (rem >= Val[d] && mdl_tube[d] > 0) begin
        oh = 4'b0001 << d;
        for (int e = 0; e < E; e++) begin exp_ej.push_back(oh); exp_dn.push_back(1'b0); end
        for (int g = 0; g < G + 1; g++) begin exp_ej.push_back(4'b0); exp_dn.push_back(1'b0); end
        rem = rem - Val[d];
        mdl_tube[d] = mdl_tube[d] - 1;
      end
    end
    exp_ej.push_back(4'b0);
    exp_dn.push_back(1'b1);

    bus.start = 1'b1;
    bus.change_amt = amt;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.eject !== 4'b0) begin
      errors++;
      $display("FAIL %s select busy/eject got %b/%b want 1/0000", name, bus.busy, bus.eject);
    end
    for (int j = 0; j < exp_ej.size(); j++) begin
      if (noise) begin
        bus.start = 1'($urandom_range(0, 1));
        bus.change_amt = 8'($urandom);
        bus.refill = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus.eject !== exp_ej[j] || bus.done !== exp_dn[j] || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL %s cycle %0d eject/done/busy got %b/%b/%b want %b/%b/1", name, j,
                 bus.eject, bus.done, bus.busy, exp_ej[j], exp_dn[j]);
      end
    end
    bus.start = 1'b0;
    bus.refill = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.short !== (rem != 0) ||
        bus.remaining !== 8'(rem) || bus.tube_empty !== mdl_empty()) begin
      errors++;
      $display("FAIL %s idle busy/done/short/rem/empty got %b/%b/%b/%0d/%b want 0/0/%b/%0d/%b",
               name, bus.busy, bus.done, bus.short, bus.remaining, bus.tube_empty,
               rem != 0, rem, mdl_empty());
    end
  endtask

  task automatic do_refill(input string name);
    bus.refill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.refill = 1'b0;
    mdl_fill();
    checks++;
    if (bus.tube_empty !== 4'b0000 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s refill empty/busy got %b/%b want 0000/0", name, bus.tube_empty, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.eject !== 4'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.short !== 1'b0 ||
        bus.remaining !== 8'd0 || bus.tube_empty !== 4'b0) begin
      errors++;
      $display("FAIL reset outputs got ej=%b busy=%b done=%b short=%b rem=%0d empty=%b want 0s",
               bus.eject, bus.busy, bus.done, bus.short, bus.remaining, bus.tube_empty);
    end
    rst_n = 1'b1;
    mdl_fill();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy got %b want 0", bus.busy);
    end
  endtask

  task automatic test_change_33();
    run_req(8'd33, 1'b0, "change33");
  endtask

  task automatic test_exhaust();
    apply_reset();
    run_req(8'd80, 1'b0, "pay80");
    checks++;
    if (bus.tube_empty !== 4'b1100) begin
      errors++;
      $display("FAIL pay80 tube_empty got %b want 1100", bus.tube_empty);
    end
    run_req(8'd10, 1'b0, "pay10");
    checks++;
    if (bus.short !== 1'b1 || bus.remaining !== 8'd6 || bus.tube_empty !== 4'b1111) begin
      errors++;
      $display("FAIL pay10 short/rem/empty got %b/%0d/%b want 1/6/1111",
               bus.short, bus.remaining, bus.tube_empty);
    end
  endtask

  task automatic test_refill();
    run_req(8'd7, 1'b1, "refill_busy");
    checks++;
    if (bus.tube_empty !== 4'b1111) begin
      errors++;
      $display("FAIL refill_busy tube_empty got %b want 1111", bus.tube_empty);
    end
    do_refill("refill_idle");
  endtask

  task automatic test_zero();
    run_req(8'd0, 1'b0, "zero");
  endtask

  task automatic test_abort();
    bus.start = 1'b1;
    bus.change_amt = 8'd40;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    // Now in the first eject: raise abort and a competing start.
    bus.abort = 1'b1;
    bus.start = 1'b1;
    bus.change_amt = 8'd5;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.eject !== 4'b1000) begin
      errors++;
      $display("FAIL abort eject_hold got %b want 1000", bus.eject);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.eject !== 4'b0000 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL abort gap eject/done got %b/%b want 0000/0", bus.eject, bus.done);
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.done !== 1'b1 || bus.eject !== 4'b0000) begin
      errors++;
      $display("FAIL abort done/eject got %b/%b want 1/0000", bus.done, bus.eject);
    end
    bus.abort = 1'b0;
    bus.start = 1'b0;
    mdl_tube[3] = mdl_tube[3] - 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.short !== 1'b1 || bus.remaining !== 8'd20 || bus.busy !== 1'b0 ||
        bus.tube_empty !== mdl_empty()) begin
      errors++;
      $display("FAIL abort idle short/rem/busy/empty got %b/%0d/%b/%b want 1/20/0/%b",
               bus.short, bus.remaining, bus.busy, bus.tube_empty, mdl_empty());
    end
  endtask

  task automatic test_reset_mid();
    bus.start = 1'b1;
    bus.change_amt = 8'd40;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.eject !== 4'b1000) begin
      errors++;
      $display("FAIL rstmid eject_before got %b want 1000", bus.eject);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.eject !== 4'b0 || bus.busy !== 1'b0 || bus.remaining !== 8'd0 ||
        bus.tube_empty !== 4'b0) begin
      errors++;
      $display("FAIL rstmid async eject/busy/rem/empty got %b/%b/%0d/%b want 0000/0/0/0000",
               bus.eject, bus.busy, bus.remaining, bus.tube_empty);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_fill();
    run_req(8'd33, 1'b0, "after_rst");
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      if ($urandom_range(0, 3) == 0) do_refill("rand_refill");
      run_req(8'($urandom_range(0, 120)), 1'b1, "random");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.change_amt = 8'd0;
    bus.abort = 1'b0;
    bus.refill = 1'b0;
    test_reset();
    test_change_33();
    test_exhaust();
    test_refill();
    test_zero();
    test_abort();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
